conv_encoder: RTL
=================

// Module: conv_encoder
// PURPOSE
//  Rate-1/2, K=7 convolutional encoder; transmit-side counterpart of viterbi_decoder (64-state trellis).
//  Accepts one data bit per handshake and emits one 2-bit code symbol per bit; appends K-1 zero tail bits per frame (zero-terminated trellis).
//  Output d_out[1:0] feeds viterbi_decoder d_in[1:0] directly. Valid/ready on both sides, single output register stage.
// PARAMETERS
//  K   7        constraint length; shift register holds K-1 bits
//  G0  7'o171   generator polynomial for d_out[1]; MSB taps the newest bit
//  G1  7'o133   generator polynomial for d_out[0]
// PORTS
//  clk          in   1  single clock, rising edge
//  RST          in   1  asynchronous reset, active-high
//  d_in_valid   in   1  input bit valid
//  d_in_ready   out  1  encoder accepts d_in this cycle
//  d_in         in   1  data bit
//  d_in_last    in   1  accepted bit is the last data bit of the frame
//  d_out_valid  out  1  code symbol valid
//  d_out_ready  in   1  downstream accepts symbol
//  d_out        out  2  code symbol {c0(G0), c1(G1)}
//  d_out_last   out  1  symbol is the final tail symbol of the frame
//  d_out_erase  out  2  per-bit puncture/erasure flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, RST=1): sr=0, state=IDLE, tail_cnt=0, d_out_valid=0, d_out=0, d_out_last=0, d_out_erase=0, punct phase=0.
//  slot_free = !d_out_valid | d_out_ready. d_in_ready = (state!=TAIL) & slot_free (combinational, not a function of d_in_valid).
//  Accept = d_in_valid & d_in_ready. On accept: full={d_in,sr}; c0=^(full&G0); c1=^(full&G1);
//    sr<={d_in,sr[K-2:1]}; d_out<={c0,c1}; d_out_valid<=1. Latency: symbol valid the cycle after accept.
//  Output hold: while d_out_valid & !d_out_ready, d_out/d_out_last/d_out_erase stay stable; nothing advances.
//  d_out_valid cleared when d_out_ready=1 and no new symbol is produced that cycle.
//  FSM:
//   IDLE: sr==0. Accept & !d_in_last -> DATA. Accept & d_in_last -> TAIL (1-bit frame).
//   DATA: Accept & d_in_last -> TAIL; otherwise remain.
//   TAIL: d_in_ready=0. Each cycle with slot_free encodes a 0 bit (same equations); tail_cnt++.
//         Symbol for tail_cnt==K-2 has d_out_last=1; then tail_cnt<=0, sr is zero, -> IDLE.
//  Exactly (frame bits + K-1) symbols per frame; back-to-back frames: new frame accepted in cycle after last tail symbol is issued.
//  d_in_valid with d_in_ready=0: no effect; source holds data.
//  Reset mid-frame: frame abandoned, sr cleared, no tail emitted, pending symbol dropped.
// CONFIGURATION
//  `CONV_ENC_PUNCT_EN defined: rate-2/3 puncturing on data symbols. Phase toggles per data symbol, cleared at frame start.
//   Phase 0: both bits sent, d_out_erase=2'b00. Phase 1: c1 punctured, d_out[0]=0, d_out_erase=2'b01.
//   Tail symbols never punctured (erase=00). Symbol count/timing unchanged; decoder treats erased bit as zero-metric.
//  Not defined: no puncturing, d_out_erase tied 2'b00, phase logic absent.
// STRUCTURE
//  Shared package viterbi_pkg: K, G0/G1 defaults, enc_state_t enum {IDLE,DATA,TAIL}, TAIL_LEN=K-1.
//  Sub-module conv_enc_core: combinational parity {c0,c1} from {bit,sr} and next-sr; top holds FSM, tail counter, output register.
// TESTING
//  1) Impulse: bit 1 + last, ready=1 -> d_out 11,10,11,11,00,01,11; d_out_last only on 7th; back in IDLE.
//  2) All-zero 8-bit frame -> 14 symbols of 00, last on 14th; d_in_ready=0 for 6 tail cycles.
//  3) Backpressure: d_out_ready=0 for 5 cycles mid-frame -> d_out stable, d_in_ready=0, no bit lost/duplicated vs model.
//  4) Back-to-back frames 1,0,1(last) then 1(last) -> second frame's first symbol 11 (sr cleared by tail).
//  5) RST pulse during TAIL (tail_cnt=3) -> all outputs 0 next cycle; next frame encodes from sr=0.
//  6) PUNCT_EN: frame 1,1,1,1(last) -> erase 00,01,00,01 then 00 on all tail; d_out[0]=0 on punctured symbols.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=7 rate-1/2 encoder/decoder pair.
package viterbi_pkg;
  localparam int          K        = 7;
  localparam logic [6:0]  G0       = 7'o171;
  localparam logic [6:0]  G1       = 7'o133;
  localparam int          TAIL_LEN = K - 1;
  localparam int          CNT_W    = $clog2(TAIL_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;
endpackage

// File: rtl/conv_enc_core.sv
// Combinational parity and shift-register update for one encoded bit.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic         bit_i,
  input  logic [K-2:0] sr_i,
  output logic [1:0]   sym_o,
  output logic [K-2:0] sr_nxt_o
);
  logic [K-1:0] full;

  // Newest bit sits in the MSB so it lines up with the generator MSB tap.
  assign full     = {bit_i, sr_i};
  assign sym_o    = {^(full & G0), ^(full & G1)};
  assign sr_nxt_o = {bit_i, sr_i[K-2:1]};
endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 zero-terminated convolutional encoder with one output register.
// Define CONV_ENC_PUNCT_EN for rate-2/3 puncturing of data symbols.
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       d_in_valid,
  output logic       d_in_ready,
  input  logic       d_in,
  input  logic       d_in_last,
  output logic       d_out_valid,
  input  logic       d_out_ready,
  output logic [1:0] d_out,
  output logic       d_out_last,
  output logic [1:0] d_out_erase
);
  enc_state_t       state_q, state_d;
  logic [K-2:0]     sr_q, sr_nxt;
  logic [CNT_W-1:0] tail_cnt_q;
  logic             vld_q, last_q;
  logic [1:0]       dout_q, erase_q, sym;
  logic             slot_free, acc, tail_fire, tail_end, fire, enc_bit, punct;

  assign slot_free  = !vld_q || d_out_ready;
  assign d_in_ready = (state_q != TAIL) && slot_free;
  assign acc        = d_in_valid && d_in_ready;
  assign tail_fire  = (state_q == TAIL) && slot_free;
  assign tail_end   = tail_fire && (tail_cnt_q == CNT_W'(TAIL_LEN - 1));
  assign fire       = acc || tail_fire;
  assign enc_bit    = acc && d_in;

  conv_enc_core u_core (
    .bit_i    (enc_bit),
    .sr_i     (sr_q),
    .sym_o    (sym),
    .sr_nxt_o (sr_nxt)
  );

`ifdef CONV_ENC_PUNCT_EN
  logic phase_q, phase_cur;

  // Phase restarts at 0 on the first bit of every frame.
  assign phase_cur = (state_q != IDLE) && phase_q;
  assign punct     = acc && phase_cur;

  always_ff @(posedge clk or posedge RST) begin
    if (RST)      phase_q <= 1'b0;
    else if (acc) phase_q <= !phase_cur;
  end
`else
  assign punct = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DATA: if (acc) state_d = d_in_last ? TAIL : DATA;
      TAIL:       if (tail_end) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      tail_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (fire) sr_q <= sr_nxt;
      if (tail_fire) tail_cnt_q <= tail_end ? '0 : tail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      vld_q   <= 1'b0;
      dout_q  <= 2'b00;
      last_q  <= 1'b0;
      erase_q <= 2'b00;
    end else if (fire) begin
      vld_q   <= 1'b1;
      dout_q  <= {sym[1], sym[0] && !punct};
      last_q  <= tail_end;
      erase_q <= {1'b0, punct};
    end else if (d_out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign d_out_valid = vld_q;
  assign d_out       = dout_q;
  assign d_out_last  = last_q;
  assign d_out_erase = erase_q;
endmodule
